press_classifier: RTL

PRESS_CLASSIFIER -- requirements
Module: press_classifier

---
 rtl/press_pkg.sv | 18 +
 rtl/press_channel.sv | 128 ++++++++++++
 rtl/press_classifier.sv | 51 +++++
 3 files changed

// File: rtl/press_pkg.sv
// Shared types and sizing helpers for the press classifier.
// Holds the per-channel FSM state encoding and the hold-counter width function.
package press_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } press_state_t;

    // Hold counter must reach whichever of the long and repeat thresholds is larger
    function automatic int cnt_width(input int long_cycles, input int repeat_cycles);
        int max_c;
        max_c = (long_cycles > repeat_cycles) ? long_cycles : repeat_cycles;
        return $clog2(max_c + 1);
    endfunction

endpackage

// File: rtl/press_channel.sv
// One button channel: 2-flop synchronizer, debounce filter and press classifier FSM.
// All pulse outputs and the debounced level are registered.
module press_channel
    import press_pkg::*;
#(
    parameter int DEB_CYCLES    = 8,
    parameter int LONG_CYCLES   = 16,
    parameter int REPEAT_CYCLES = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    input  logic repeat_en,
    output logic short_p,
    output logic long_p,
    output logic repeat_p,
    output logic held
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int CW = cnt_width(LONG_CYCLES, REPEAT_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    // The IDLE cycle that sees the rising edge is already the first high cycle
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 2);
    localparam logic [CW-1:0] REP_LAST  = CW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
    localparam bit REP_ON = (REPEAT_CYCLES > 0);

    logic          sync1_r;
    logic          sync2_r;
    logic [DW-1:0] deb_cnt_r;
    logic          held_r;
    press_state_t  state_r;
    logic [CW-1:0] hold_cnt_r;
    logic          short_r;
    logic          long_r;
    logic          repeat_r;

    // Two-flop synchronizer for the asynchronous button level
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: accept a level change only after DEB_CYCLES consecutive differing cycles
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            deb_cnt_r <= '0;
            held_r    <= 1'b0;
        end else if (sync2_r != held_r) begin
            if (deb_cnt_r == DEB_LAST) begin
                held_r    <= ~held_r;
                deb_cnt_r <= '0;
            end else begin
                deb_cnt_r <= deb_cnt_r + DW'(1);
            end
        end else begin
            deb_cnt_r <= '0;
        end
    end

    // Press classification FSM with registered one-cycle pulses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            hold_cnt_r <= '0;
            short_r    <= 1'b0;
            long_r     <= 1'b0;
            repeat_r   <= 1'b0;
        end else begin
            short_r  <= 1'b0;
            long_r   <= 1'b0;
            repeat_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    hold_cnt_r <= '0;
                    if (held_r) begin
                        state_r <= PRESSED;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                PRESSED: begin
                    if (!held_r) begin
                        short_r    <= 1'b1;
                        state_r    <= IDLE;
                        hold_cnt_r <= '0;
                    end else if (hold_cnt_r == LONG_LAST) begin
                        long_r     <= 1'b1;
                        state_r    <= LONG_HELD;
                        hold_cnt_r <= '0;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + CW'(1);
                    end
                end
                LONG_HELD: begin
                    if (!held_r) begin
                        state_r    <= IDLE;
                        hold_cnt_r <= '0;
                    end else if (REP_ON && repeat_en) begin
                        if (hold_cnt_r == REP_LAST) begin
                            repeat_r   <= 1'b1;
                            hold_cnt_r <= '0;
                        end else begin
                            hold_cnt_r <= hold_cnt_r + CW'(1);
                        end
                    end else begin
                        hold_cnt_r <= '0;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    hold_cnt_r <= '0;
                end
            endcase
        end
    end

    assign short_p  = short_r;
    assign long_p   = long_r;
    assign repeat_p = repeat_r;
    assign held     = held_r;

endmodule

// File: rtl/press_classifier.sv
// Multi-channel button press classifier: short, long and auto-repeat pulses.
// Channels are fully independent and share only clock and reset.
module press_classifier
    import press_pkg::*;
#(
    parameter int N_CH          = 3,
    parameter int DEB_CYCLES    = 8,
    parameter int LONG_CYCLES   = 16,
    parameter int REPEAT_CYCLES = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N_CH-1:0] btn,
    input  logic [N_CH-1:0] repeat_en,
    output logic [N_CH-1:0] short_p,
    output logic [N_CH-1:0] long_p,
    output logic [N_CH-1:0] repeat_p,
    output logic [N_CH-1:0] held
);

    if (N_CH < 1 || N_CH > 16) begin : g_bad_n_ch
        $error("press_classifier: N_CH must be in 1..16");
    end
    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("press_classifier: DEB_CYCLES must be at least 1");
    end
    if (LONG_CYCLES < 2) begin : g_bad_long
        $error("press_classifier: LONG_CYCLES must be at least 2");
    end
    if (REPEAT_CYCLES < 0) begin : g_bad_rep
        $error("press_classifier: REPEAT_CYCLES must not be negative");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        press_channel #(
            .DEB_CYCLES    (DEB_CYCLES),
            .LONG_CYCLES   (LONG_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_channel (
            .clock     (clock),
            .reset     (reset),
            .btn       (btn[i]),
            .repeat_en (repeat_en[i]),
            .short_p   (short_p[i]),
            .long_p    (long_p[i]),
            .repeat_p  (repeat_p[i]),
            .held      (held[i])
        );
    end

endmodule
